// File: rtl/fll_cfg_pkg.sv
// Shared types and constants for the FLL configuration sequencer.
// State encoding, FLL register map and the latched request record.
package fll_cfg_pkg;

    typedef logic [2:0] fll_state_t;

    localparam fll_state_t ST_SYNC      = 3'd0;
    localparam fll_state_t ST_BOOT      = 3'd1;
    localparam fll_state_t ST_IDLE      = 3'd2;
    localparam fll_state_t ST_REQ       = 3'd3;
    localparam fll_state_t ST_RELEASE   = 3'd4;
    localparam fll_state_t ST_WAIT_LOCK = 3'd5;
    localparam fll_state_t ST_RESP      = 3'd6;

    localparam logic [1:0] FLL_STATUS  = 2'd0;
    localparam logic [1:0] FLL_CONFIG1 = 2'd1;
    localparam logic [1:0] FLL_CONFIG2 = 2'd2;
    localparam logic [1:0] FLL_INTEG   = 2'd3;

    typedef struct packed {
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
    } fll_cfg_req_t;

    // A CONFIG1 write retunes the loop, so the sequencer must wait for relock.
    function automatic logic is_cfg1_write(input fll_cfg_req_t r);
        return r.we && (r.addr == FLL_CONFIG1);
    endfunction

endpackage

// File: rtl/fll_cfg_rr_arb.sv
// Round-robin requester select: first pending index at or above the pointer,
// wrapping to the lowest pending index; pointer advances past each grant.
module fll_cfg_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               en_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic [NUM_REQ-1:0] gnt_oh_o
);
    import fll_cfg_pkg::*;

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] idx_lo, idx_hi;
    logic             found_hi;

    always_comb begin
        idx_lo   = '0;
        idx_hi   = '0;
        found_hi = 1'b0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_i[j]) begin
                idx_lo = IDX_W'(j);
                if (j >= int'(ptr_q)) begin
                    idx_hi   = IDX_W'(j);
                    found_hi = 1'b1;
                end
            end
        end
        valid_o = |req_i;
        idx_o   = found_hi ? idx_hi : idx_lo;
    end

    always_comb begin
        for (int j = 0; j < NUM_REQ; j++) begin
            gnt_oh_o[j] = en_i && valid_o && (idx_o == IDX_W'(j));
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (en_i && valid_o) begin
            ptr_d = (idx_o == IDX_W'(NUM_REQ - 1)) ? '0 : idx_o + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/fll_cfg_ctrl.sv
// Configuration sequencer for one FLL macro: optional boot write, round-robin
// sharing of the 4-phase config port, and bounded relock wait after CONFIG1 writes.
module fll_cfg_ctrl #(
    parameter int          NUM_REQ      = 2,
    parameter int          LOCK_TIMEOUT = 1024,
    parameter bit          BOOT_EN      = 1'b1,
    parameter logic [31:0] BOOT_CFG1    = 32'h0000_05F5
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_REQ-1:0]    req_i,
    input  logic [NUM_REQ-1:0]    req_we_i,
    input  logic [2*NUM_REQ-1:0]  req_addr_i,
    input  logic [32*NUM_REQ-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]    gnt_o,
    output logic [NUM_REQ-1:0]    rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  rerr_o,
    output logic                  fll_req_o,
    input  logic                  fll_ack_i,
    output logic [1:0]            fll_add_o,
    output logic [31:0]           fll_data_o,
    input  logic [31:0]           fll_r_data_i,
    output logic                  fll_wrn_o,
    input  logic                  fll_lock_i,
    output logic                  busy_o,
    output logic                  boot_done_o,
    output logic                  lock_timeout_o
);
    import fll_cfg_pkg::*;

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

    fll_state_t       state_q, state_d;
    fll_cfg_req_t     tx_q, tx_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             boot_tx_q, boot_tx_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rerr_q, rerr_d;
    logic             lto_q, lto_d;
    logic             boot_done_q, boot_done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             arb_valid;
    logic [IDX_W-1:0] arb_idx;
    logic [1:0]       addr_a  [NUM_REQ];
    logic [31:0]      wdata_a [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_a[g]   = req_addr_i[2*g +: 2];
        assign wdata_a[g]  = req_wdata_i[32*g +: 32];
        assign rvalid_o[g] = (state_q == ST_RESP) && !boot_tx_q && (idx_q == IDX_W'(g));
    end

    fll_cfg_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .en_i     (state_q == ST_IDLE),
        .valid_o  (arb_valid),
        .idx_o    (arb_idx),
        .gnt_oh_o (gnt_o)
    );

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        idx_d       = idx_q;
        boot_tx_d   = boot_tx_q;
        rdata_d     = rdata_q;
        rerr_d      = rerr_q;
        lto_d       = lto_q;
        boot_done_d = boot_done_q;
        cnt_d       = cnt_q;
        case (state_q)
            // An ack still high here belongs to a handshake cut short by reset.
            ST_SYNC: begin
                if (!fll_ack_i) begin
                    if (BOOT_EN) begin
                        state_d = ST_BOOT;
                    end else begin
                        state_d     = ST_IDLE;
                        boot_done_d = 1'b1;
                    end
                end
            end
            ST_BOOT: begin
                tx_d      = '{we: 1'b1, addr: FLL_CONFIG1, wdata: BOOT_CFG1};
                boot_tx_d = 1'b1;
                rerr_d    = 1'b0;
                state_d   = ST_REQ;
            end
            ST_IDLE: begin
                if (arb_valid) begin
                    tx_d      = '{we: req_we_i[arb_idx], addr: addr_a[arb_idx], wdata: wdata_a[arb_idx]};
                    idx_d     = arb_idx;
                    boot_tx_d = 1'b0;
                    rerr_d    = 1'b0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                if (fll_ack_i) begin
                    rdata_d = fll_r_data_i;
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!fll_ack_i) begin
                    if (is_cfg1_write(tx_q)) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT_LOCK;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT_LOCK: begin
                if (fll_lock_i) begin
                    lto_d   = 1'b0;
                    rerr_d  = 1'b0;
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    lto_d   = 1'b1;
                    rerr_d  = 1'b1;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                if (boot_tx_q) begin
                    boot_done_d = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_SYNC;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_SYNC;
            tx_q        <= '0;
            idx_q       <= '0;
            boot_tx_q   <= 1'b0;
            rdata_q     <= '0;
            rerr_q      <= 1'b0;
            lto_q       <= 1'b0;
            boot_done_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            idx_q       <= idx_d;
            boot_tx_q   <= boot_tx_d;
            rdata_q     <= rdata_d;
            rerr_q      <= rerr_d;
            lto_q       <= lto_d;
            boot_done_q <= boot_done_d;
            cnt_q       <= cnt_d;
        end
    end

    assign fll_req_o      = (state_q == ST_REQ);
    assign fll_add_o      = tx_q.addr;
    assign fll_data_o     = tx_q.wdata;
    assign fll_wrn_o      = ~tx_q.we;
    assign rdata_o        = rdata_q;
    assign rerr_o         = rerr_q;
    assign busy_o         = (state_q != ST_IDLE);
    assign boot_done_o    = boot_done_q;
    assign lock_timeout_o = lto_q;

endmodule

// File: tb/tb_fll_cfg_ctrl.sv
// Bench for fll_cfg_ctrl against a stub FLL with combinational, delayed or
// forced acknowledge; responses are checked through an expectation queue.
module tb_fll_cfg_ctrl;

    localparam int NREQ = 2;
    localparam int LT   = 8;

    logic              clk = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NREQ-1:0]   req_i = '0;
    logic [NREQ-1:0]   req_we_i = '0;
    logic [2*NREQ-1:0] req_addr_i = '0;
    logic [32*NREQ-1:0] req_wdata_i = '0;
    logic [NREQ-1:0]   gnt_o, rvalid_o;
    logic [31:0]       rdata_o;
    logic              rerr_o;
    logic              fll_req_o, fll_ack_i, fll_wrn_o, fll_lock_i;
    logic [1:0]        fll_add_o;
    logic [31:0]       fll_data_o;
    logic [31:0]       fll_r_data_i = '0;
    logic              busy_o, boot_done_o, lock_timeout_o;

    logic lock_m    = 1'b1;
    logic ack_mode  = 1'b0;
    logic force_ack = 1'b0;
    logic ack_dly   = 1'b0;
    int   req_cnt   = 0;
    int   rel_cnt   = 0;

    typedef struct {
        logic [NREQ-1:0] oh;
        logic [31:0]     rdata;
        logic            rerr;
    } exp_t;
    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign fll_lock_i = lock_m;
    assign fll_ack_i  = force_ack | (ack_mode ? ack_dly : fll_req_o);

    // Delayed ack stub: rises 3 cycles after req, falls 2 cycles after req drops.
    always @(posedge clk) begin
        if (fll_req_o) begin
            req_cnt <= req_cnt + 1;
            rel_cnt <= 0;
            if (req_cnt >= 2) ack_dly <= 1'b1;
        end else begin
            req_cnt <= 0;
            if (ack_dly) begin
                rel_cnt <= rel_cnt + 1;
                if (rel_cnt >= 1) begin
                    ack_dly <= 1'b0;
                    rel_cnt <= 0;
                end
            end
        end
    end

    fll_cfg_ctrl #(
        .NUM_REQ      (NREQ),
        .LOCK_TIMEOUT (LT),
        .BOOT_EN      (1'b1),
        .BOOT_CFG1    (32'h0000_05F5)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .req_i          (req_i),
        .req_we_i       (req_we_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .gnt_o          (gnt_o),
        .rvalid_o       (rvalid_o),
        .rdata_o        (rdata_o),
        .rerr_o         (rerr_o),
        .fll_req_o      (fll_req_o),
        .fll_ack_i      (fll_ack_i),
        .fll_add_o      (fll_add_o),
        .fll_data_o     (fll_data_o),
        .fll_r_data_i   (fll_r_data_i),
        .fll_wrn_o      (fll_wrn_o),
        .fll_lock_i     (fll_lock_i),
        .busy_o         (busy_o),
        .boot_done_o    (boot_done_o),
        .lock_timeout_o (lock_timeout_o)
    );

    task automatic drive_req(input int idx, input logic we, input logic [1:0] addr, input logic [31:0] wd);
        req_i                    = NREQ'(1) << idx;
        req_we_i[idx]            = we;
        req_addr_i[idx*2 +: 2]   = addr;
        req_wdata_i[idx*32 +: 32] = wd;
    endtask

    // Single transaction from an idle controller; lat counts cycles from grant to rvalid.
    task automatic run_single(input int idx, input logic we, input logic [1:0] addr, input logic [31:0] wd,
                              output logic [NREQ-1:0] g, output int lat, output logic [NREQ-1:0] rv,
                              output logic [31:0] rd, output logic re, output logic lto);
        @(negedge clk);
        drive_req(idx, we, addr, wd);
        #1 g = gnt_o;
        @(negedge clk);
        req_i = '0;
        lat = 1;
        while (rvalid_o == '0 && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        rv  = rvalid_o;
        rd  = rdata_o;
        re  = rerr_o;
        lto = lock_timeout_o;
    endtask

    task automatic test_reset();
        logic [47:0] got, exp;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk);
        got = {gnt_o, rvalid_o, rerr_o, fll_req_o, fll_wrn_o, fll_add_o, busy_o, boot_done_o, lock_timeout_o, 3'b000, rdata_o[31:0] == 32'd0, fll_data_o == 32'd0, 27'd0};
        exp = {2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b1, 27'd0};
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL reset_state: got %h, expected %h", got, exp);
        end
        n_checks++;
        if (rdata_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h, expected 0", rdata_o);
        end
    endtask

    task automatic test_boot();
        int req_hi = 0, bad = 0, early = 0, rv_seen = 0, done_at = -1;
        rst_ni = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (fll_req_o) begin
                req_hi++;
                if (fll_add_o !== 2'd1 || fll_data_o !== 32'h0000_05F5 || fll_wrn_o !== 1'b0) bad++;
            end
            if (gnt_o != '0 && !boot_done_o) early++;
            if (rvalid_o != '0) rv_seen++;
            if (boot_done_o && done_at < 0) done_at = i;
        end
        n_checks++;
        if (req_hi != 1) begin n_fail++; $display("FAIL boot_req_cycles: got %0d, expected 1", req_hi); end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL boot_fields: got %0d bad cycles, expected 0", bad); end
        n_checks++;
        if (done_at < 0) begin n_fail++; $display("FAIL boot_done_within_6: got none, expected rise by cycle 6"); end
        n_checks++;
        if (early != 0 || rv_seen != 0) begin
            n_fail++;
            $display("FAIL boot_no_gnt_rvalid: got gnt %0d rvalid %0d, expected 0 0", early, rv_seen);
        end
    endtask

    task automatic test_back_to_back();
        int grants = 0, resps = 0, cyc = 0, ptr_m = 0;
        bit drop = 0;
        exp_t e;
        logic [NREQ-1:0] exp_g;
        @(negedge clk);
        drive_req(0, 1'b0, 2'd2, 32'd0);
        req_i = 2'b11;
        req_we_i[1] = 1'b0;
        req_addr_i[3:2] = 2'd3;
        while (resps < 4 && cyc < 200) begin
            #1;
            if (gnt_o != '0) begin
                exp_g = NREQ'(1) << ptr_m;
                n_checks++;
                if (gnt_o !== exp_g) begin
                    n_fail++;
                    $display("FAIL rr_gnt_%0d: got %b, expected %b", grants, gnt_o, exp_g);
                end
                fll_r_data_i = 32'hA000_0000 | grants;
                sb.push_back('{oh: exp_g, rdata: 32'hA000_0000 | grants, rerr: 1'b0});
                ptr_m = (ptr_m + 1) % NREQ;
                grants++;
                if (grants == 4) drop = 1;
            end
            if (rvalid_o != '0) begin
                e = sb.pop_front();
                n_checks++;
                if (rvalid_o !== e.oh || rdata_o !== e.rdata || rerr_o !== e.rerr) begin
                    n_fail++;
                    $display("FAIL rr_resp_%0d: got rv %b data %h err %b, expected rv %b data %h err %b",
                             resps, rvalid_o, rdata_o, rerr_o, e.oh, e.rdata, e.rerr);
                end
                resps++;
            end
            @(negedge clk);
            cyc++;
            if (drop) begin
                req_i = '0;
                drop  = 0;
            end
        end
        req_i = '0;
        n_checks++;
        if (resps != 4) begin n_fail++; $display("FAIL rr_timeout: got %0d responses, expected 4", resps); end
    endtask

    task automatic test_read();
        logic [NREQ-1:0] g, rv;
        logic [31:0] rd;
        logic re, lto;
        int lat;
        exp_t e;
        fll_r_data_i = 32'hDEAD_BEEF;
        sb.push_back('{oh: 2'b01, rdata: 32'hDEAD_BEEF, rerr: 1'b0});
        run_single(0, 1'b0, 2'd2, 32'd0, g, lat, rv, rd, re, lto);
        e = sb.pop_front();
        n_checks++;
        if (g !== 2'b01) begin n_fail++; $display("FAIL read_gnt: got %b, expected 01", g); end
        n_checks++;
        if (lat != 3) begin n_fail++; $display("FAIL read_latency: got %0d, expected 3", lat); end
        n_checks++;
        if (rv !== e.oh || rd !== e.rdata || re !== e.rerr) begin
            n_fail++;
            $display("FAIL read_resp: got rv %b data %h err %b, expected rv %b data %h err %b", rv, rd, re, e.oh, e.rdata, e.rerr);
        end
    endtask

    task automatic test_lock_timeout();
        logic [NREQ-1:0] g, rv;
        logic [31:0] rd;
        logic re, lto;
        int lat;
        exp_t e;
        lock_m = 1'b0;
        fll_r_data_i = 32'h0BAD_F00D;
        sb.push_back('{oh: 2'b01, rdata: 32'h0BAD_F00D, rerr: 1'b1});
        run_single(0, 1'b1, 2'd1, 32'h0000_1234, g, lat, rv, rd, re, lto);
        e = sb.pop_front();
        n_checks++;
        if (lat != 3 + LT) begin n_fail++; $display("FAIL timeout_latency: got %0d, expected %0d", lat, 3 + LT); end
        n_checks++;
        if (rv !== e.oh || rd !== e.rdata || re !== e.rerr) begin
            n_fail++;
            $display("FAIL timeout_resp: got rv %b data %h err %b, expected rv %b data %h err %b", rv, rd, re, e.oh, e.rdata, e.rerr);
        end
        n_checks++;
        if (lto !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b, expected 1", lto); end
        @(negedge clk);
        n_checks++;
        if (lock_timeout_o !== 1'b1) begin n_fail++; $display("FAIL timeout_hold: got %b, expected 1", lock_timeout_o); end

        lock_m = 1'b1;
        fll_r_data_i = 32'h0000_0077;
        sb.push_back('{oh: 2'b10, rdata: 32'h0000_0077, rerr: 1'b0});
        run_single(1, 1'b1, 2'd1, 32'h0000_0555, g, lat, rv, rd, re, lto);
        e = sb.pop_front();
        n_checks++;
        if (lat != 4) begin n_fail++; $display("FAIL relock_latency: got %0d, expected 4", lat); end
        n_checks++;
        if (rv !== e.oh || rd !== e.rdata || re !== e.rerr || lto !== 1'b0) begin
            n_fail++;
            $display("FAIL relock_resp: got rv %b data %h err %b lto %b, expected rv %b data %h err %b lto 0",
                     rv, rd, re, lto, e.oh, e.rdata, e.rerr);
        end
    endtask

    task automatic test_delayed_ack();
        int cyc = 1, fall_cyc = -1, rv_cyc = -1, req_cycles = 0, bad = 0;
        logic ack_prev;
        exp_t e;
        ack_mode = 1'b1;
        fll_r_data_i = 32'hCAFE_0001;
        sb.push_back('{oh: 2'b01, rdata: 32'hCAFE_0001, rerr: 1'b0});
        @(negedge clk);
        drive_req(0, 1'b1, 2'd3, 32'h5A5A_1234);
        #1;
        n_checks++;
        if (gnt_o !== 2'b01) begin n_fail++; $display("FAIL dly_gnt: got %b, expected 01", gnt_o); end
        @(negedge clk);
        req_i = '0;
        ack_prev = fll_ack_i;
        while (rv_cyc < 0 && cyc < 60) begin
            if (fll_req_o) begin
                req_cycles++;
                if (fll_add_o !== 2'd3 || fll_data_o !== 32'h5A5A_1234 || fll_wrn_o !== 1'b0) bad++;
            end
            if (ack_prev && !fll_ack_i && fall_cyc < 0) fall_cyc = cyc;
            ack_prev = fll_ack_i;
            if (rvalid_o != '0) begin
                rv_cyc = cyc;
                e = sb.pop_front();
                n_checks++;
                if (rvalid_o !== e.oh || rdata_o !== e.rdata || rerr_o !== e.rerr) begin
                    n_fail++;
                    $display("FAIL dly_resp: got rv %b data %h err %b, expected rv %b data %h err %b",
                             rvalid_o, rdata_o, rerr_o, e.oh, e.rdata, e.rerr);
                end
            end
            @(negedge clk);
            cyc++;
        end
        ack_mode = 1'b0;
        n_checks++;
        if (req_cycles != 4 || bad != 0) begin
            n_fail++;
            $display("FAIL dly_req_stable: got %0d req cycles %0d unstable, expected 4 and 0", req_cycles, bad);
        end
        n_checks++;
        if (fall_cyc < 0 || rv_cyc != fall_cyc + 1) begin
            n_fail++;
            $display("FAIL dly_rvalid_after_fall: got rvalid at %0d ack fall at %0d, expected fall+1", rv_cyc, fall_cyc);
        end
    endtask

    task automatic test_reset_mid_req();
        int bad = 0, req_hi = 0, fbad = 0;
        bit done = 0;
        ack_mode = 1'b1;
        @(negedge clk);
        drive_req(0, 1'b0, 2'd0, 32'd0);
        @(negedge clk);
        req_i = '0;
        n_checks++;
        if (fll_req_o !== 1'b1) begin n_fail++; $display("FAIL mid_in_req: got %b, expected 1", fll_req_o); end
        rst_ni    = 1'b0;
        force_ack = 1'b1;
        ack_mode  = 1'b0;
        @(negedge clk);
        n_checks++;
        if (fll_req_o !== 1'b0 || busy_o !== 1'b1 || boot_done_o !== 1'b0 || lock_timeout_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_edge: got req %b busy %b boot_done %b lto %b, expected 0 1 0 0",
                     fll_req_o, busy_o, boot_done_o, lock_timeout_o);
        end
        rst_ni = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (fll_req_o !== 1'b0 || boot_done_o !== 1'b0 || busy_o !== 1'b1) bad++;
        end
        force_ack = 1'b0;
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL mid_hold_sync: got %0d bad cycles, expected 0", bad); end
        for (int i = 0; i < 10 && !done; i++) begin
            @(negedge clk);
            if (fll_req_o) begin
                req_hi++;
                if (fll_add_o !== 2'd1 || fll_data_o !== 32'h0000_05F5 || fll_wrn_o !== 1'b0) fbad++;
            end
            if (boot_done_o) done = 1;
        end
        n_checks++;
        if (!done || req_hi != 1 || fbad != 0) begin
            n_fail++;
            $display("FAIL mid_reboot: got done %0d req cycles %0d bad %0d, expected 1 1 0", done, req_hi, fbad);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_boot();
        test_back_to_back();
        test_read();
        test_lock_timeout();
        test_delayed_ack();
        test_reset_mid_req();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain: got %0d left, expected 0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fll_cfg_ctrl.md
Name: fll_cfg_ctrl

Overview:
- Configuration sequencer and arbiter for one gf22_FLL instance.
- Shares the FLL 4-phase config port (CFGREQ/CFGACK/CFGAD/CFGD/CFGQ/CFGWEB) between NUM_REQ bus requesters using round-robin arbitration.
- After reset, optionally performs a boot write of CONFIG1 before serving requesters.
- After any CONFIG1 write, waits for LOCK with a bounded timeout; sits between the SoC APB/peripheral interconnect and the FLL macro.

Parameters:
- NUM_REQ, 2, number of requesters (>=1).
- LOCK_TIMEOUT, 1024, max cycles to wait for fll_lock_i after a CONFIG1 write (>=1).
- BOOT_EN, 1, 1 = perform boot write after reset.
- BOOT_CFG1, 32'h0000_05F5, value written to CONFIG1 (addr 1) at boot.

Ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  reset, synchronous, active-low.
- req_i  in  NUM_REQ  per-requester request; held until gnt_o.
- req_we_i  in  NUM_REQ  1 = write, 0 = read.
- req_addr_i  in  2*NUM_REQ  packed FLL register address per requester.
- req_wdata_i  in  32*NUM_REQ  packed write data per requester.
- gnt_o  out  NUM_REQ  one-hot, one-cycle acceptance pulse.
- rvalid_o  out  NUM_REQ  one-hot, one-cycle response pulse to the granted requester.
- rdata_o  out  32  read data (CFGQ captured at ack); valid with rvalid_o.
- rerr_o  out  1  lock timeout on this transaction; valid with rvalid_o.
- fll_req_o  out  1  to CFGREQ.
- fll_ack_i  in  1  from CFGACK.
- fll_add_o  out  2  to CFGAD.
- fll_data_o  out  32  to CFGD.
- fll_r_data_i  in  32  from CFGQ.
- fll_wrn_o  out  1  to CFGWEB (0 = write).
- fll_lock_i  in  1  from LOCK.
- busy_o  out  1  state != IDLE.
- boot_done_o  out  1  sticky; set when boot sequence completes.
- lock_timeout_o  out  1  sticky; set on timeout, cleared on the next successful lock wait.

Behaviour:
- Reset values (rst_ni = 0 at clock edge): state SYNC.
  - gnt_o = 0, rvalid_o = 0, rerr_o = 0, fll_req_o = 0, fll_wrn_o = 1.
  - fll_add_o = 0, fll_data_o = 0, rdata_o = 0.
  - busy_o = 1, boot_done_o = 0, lock_timeout_o = 0, RR pointer = 0, timeout counter = 0.
- FSM states:
  - SYNC: wait fll_ack_i = 0. This covers reset asserted mid-handshake. Then go to BOOT if BOOT_EN, else IDLE with boot_done_o = 1.
  - BOOT: load addr = 1, data = BOOT_CFG1, write; go to REQ. No requester is granted.
  - IDLE: if any req_i, the RR arbiter picks an index, gnt_o[idx] pulses this cycle, and addr/we/wdata are latched; go to REQ. The pointer moves to idx+1 (mod NUM_REQ). Non-granted requesters stay pending.
  - REQ: fll_req_o = 1, with fll_add_o, fll_data_o and fll_wrn_o = ~we held stable. When fll_ack_i = 1, capture fll_r_data_i into rdata_o and go to RELEASE.
  - RELEASE: fll_req_o = 0. When fll_ack_i = 0:
    - go to WAIT_LOCK if write && addr == 1;
    - otherwise go to RESP.
  - WAIT_LOCK: counter increments each cycle.
    - fll_lock_i = 1 → clear lock_timeout_o, rerr_o = 0, go to RESP.
    - Counter reaching LOCK_TIMEOUT-1 without lock → set lock_timeout_o, rerr_o = 1, go to RESP.
    - Lock has priority if both occur in the same cycle.
    - Counter clears on entry.
  - RESP:
    - Boot transaction: set boot_done_o; no rvalid_o.
    - Otherwise: rvalid_o[idx] = 1 for one cycle, with rdata_o and rerr_o valid.
    - Go to IDLE.
- Latency with a combinational ack (ack = req): gnt at cycle N; REQ at N+1; RELEASE at N+2; rvalid at N+3; next gnt possible at N+4. A CONFIG1 write adds the WAIT_LOCK cycles (minimum 1).
- A req_i deasserted before gnt is dropped silently.
- rdata_o holds its value until the next ack capture.
- Address/data widths are fixed (2/32). The counter width is $clog2(LOCK_TIMEOUT+1).

Decomposition:
- fll_cfg_pkg:
  - state enum (SYNC, BOOT, IDLE, REQ, RELEASE, WAIT_LOCK, RESP);
  - FLL register address constants: FLL_STATUS = 0, FLL_CONFIG1 = 1, FLL_CONFIG2 = 2, FLL_INTEG = 3;
  - request struct {we, addr, wdata}.
- Sub-module fll_cfg_rr_arb: combinational round-robin select over req_i plus pointer register, NUM_REQ parameterised.

Test Plan:
- Reset release with BOOT_EN = 1, stub FLL (ack = req, lock = 1):
  - fll_req_o high exactly one cycle, with fll_add_o = 1, fll_data_o = 32'h05F5, fll_wrn_o = 0;
  - boot_done_o rises within 6 cycles;
  - no gnt_o before boot_done_o.
- Requester 0 reads addr 2 with CFGQ = 32'hDEAD_BEEF: gnt_o = 2'b01 at N, rvalid_o = 2'b01 at N+3, rdata_o = 32'hDEAD_BEEF, rerr_o = 0.
- Both requesters request simultaneously, held continuously, pointer 0: grants go 0, 1, 0, 1 on successive IDLE visits; each rvalid_o matches its gnt_o index.
- Write addr 1 with fll_lock_i held 0, LOCK_TIMEOUT = 8: rvalid_o after 8 WAIT_LOCK cycles with rerr_o = 1, lock_timeout_o = 1. A subsequent CONFIG1 write with lock = 1 clears lock_timeout_o.
- Delayed ack model (ack rises 3 cycles after req, falls 2 cycles after req drop): fll_add_o/fll_data_o stay stable throughout REQ; rvalid_o follows ack fall by exactly 1 cycle.
- rst_ni pulsed low while in REQ with ack held high for 4 cycles after reset release: fll_req_o = 0 on the first reset edge; controller stays in SYNC until ack = 0, then reruns boot.
